pdecoder_3to8_accum: RTL and testbench

Bit-position decoder and word rebuilder for the essential-bit datapath. It consumes a stream of 3-bit bit-position beats, each with valid/ready, a zero flag and a word-last marker, and rebuilds the 8-bit bitmask those positions describe. When the word closes, it presents the mask, its popcount and an error flag through a held valid/ready output. It sits on the consumer side of the priority-encoded position stream, wherever a PE or checker must reconstruct the original operand bitmask.

---
 rtl/bitsim_pkg.sv | 27 ++
 rtl/pdecoder_3to8_accum_if.sv | 25 ++
 rtl/pdecoder_3to8.sv | 14 +
 rtl/pdecoder_3to8_accum.sv | 82 ++++++++
 tb/tb_pdecoder_3to8_accum.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/bitsim_pkg.sv
// Shared widths, FSM state type and bit-position helpers for the essential-bit datapath.
package bitsim_pkg;

  localparam int unsigned POS_W  = 3;
  localparam int unsigned MASK_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Position 0 addresses the MSB of the mask.
  function automatic logic [MASK_W-1:0] pos_to_onehot(input logic [POS_W-1:0] pos);
    logic [MASK_W-1:0] msb;
    msb = {1'b1, {(MASK_W-1){1'b0}}};
    return msb >> pos;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MASK_W; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/pdecoder_3to8_accum_if.sv
// Position-beat input stream and rebuilt-word output stream of the decoder.
interface pdecoder_3to8_accum_if;

  logic                            in_valid;
  logic                            in_ready;
  logic [bitsim_pkg::POS_W-1:0]    in_pos;
  logic                            in_zero;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [bitsim_pkg::MASK_W-1:0]   out_mask;
  logic [bitsim_pkg::CNT_W-1:0]    out_count;
  logic                            out_err;

  modport master (
    output in_valid, in_pos, in_zero, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_count, out_err
  );

  modport slave (
    input  in_valid, in_pos, in_zero, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_count, out_err
  );

endinterface

// File: rtl/pdecoder_3to8.sv
// Combinational 3-bit position to one-hot mask decode, enabled for non-zero beats.
module pdecoder_3to8
  import bitsim_pkg::*;
(
  input  logic [POS_W-1:0]  pos,
  input  logic              zero,
  output logic [MASK_W-1:0] onehot_c,
  output logic              en_c
);

  assign onehot_c = pos_to_onehot(pos);
  assign en_c     = !zero;

endmodule

// File: rtl/pdecoder_3to8_accum.sv
// Rebuilds an 8-bit mask from a stream of bit-position beats and holds it until taken.
module pdecoder_3to8_accum
  import bitsim_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pdecoder_3to8_accum_if.slave  bus
);

  state_t              state, state_n;
  logic [MASK_W-1:0]   acc_mask, mask_n;
  logic [CNT_W-1:0]    term_cnt, cnt_n;
  logic                err_acc, err_n;
  logic [MASK_W-1:0]   onehot;
  logic                en;
  logic                accept;
  logic [CNT_W-1:0]    pop_n;

  pdecoder_3to8 u_dec (
    .pos      (bus.in_pos),
    .zero     (bus.in_zero),
    .onehot_c (onehot),
    .en_c     (en)
  );

  assign bus.in_ready  = (state == ACCUM) || bus.out_ready;
  assign bus.out_valid = (state == HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop_n         = popcount(mask_n);

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_n;
  end

  // Next accumulator value and next state; term_cnt saturates at MAX_TERMS+1.
  always_comb begin
    mask_n  = acc_mask;
    cnt_n   = term_cnt;
    err_n   = err_acc;
    state_n = state;
    if (accept && en) begin
      mask_n = acc_mask | onehot;
      if ((acc_mask & onehot) != '0) err_n = 1'b1;
      if (term_cnt >= CNT_W'(MAX_TERMS)) err_n = 1'b1;
      if (term_cnt <= CNT_W'(MAX_TERMS)) cnt_n = term_cnt + CNT_W'(1);
    end
    case (state)
      ACCUM:   if (accept && bus.in_last) state_n = HOLD;
      HOLD:    if (bus.out_ready) state_n = (accept && bus.in_last) ? HOLD : ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  // A last beat publishes the word and leaves a cleared accumulator behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_mask      <= '0;
      term_cnt      <= '0;
      err_acc       <= 1'b0;
      bus.out_mask  <= '0;
      bus.out_count <= '0;
      bus.out_err   <= 1'b0;
    end else if (accept) begin
      if (bus.in_last) begin
        acc_mask      <= '0;
        term_cnt      <= '0;
        err_acc       <= 1'b0;
        bus.out_mask  <= mask_n;
        bus.out_count <= pop_n;
        bus.out_err   <= err_n;
      end else begin
        acc_mask <= mask_n;
        term_cnt <= cnt_n;
        err_acc  <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_pdecoder_3to8_accum.sv
// Self-checking bench: directed vector table, corner sequences and a randomized scoreboard run.
module tb_pdecoder_3to8_accum;
  import bitsim_pkg::*;

  localparam int MAX1 = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pdecoder_3to8_accum_if bus ();
  pdecoder_3to8_accum_if bus2 ();

  pdecoder_3to8_accum #(.MAX_TERMS(MAX1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  pdecoder_3to8_accum #(.MAX_TERMS(2))    dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: positions of the open word, plus the single pending output word.
  int          q[$];
  bit          m_pend;
  logic [7:0]  m_mask;
  logic [3:0]  m_cnt;
  logic        m_err;

  logic        s_ready, s_valid, s_err;
  logic [7:0]  s_mask;
  logic [3:0]  s_count;

  typedef struct {
    int          n;
    logic [23:0] pos;   // beat 0 in the top three bits
    logic [7:0]  zero;  // beat 0 in bit 7
    logic [7:0]  exp_mask;
    logic [3:0]  exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_close();
    int distinct;
    m_mask = '0;
    foreach (q[i]) m_mask[7 - q[i]] = 1'b1;
    distinct = $countones(m_mask);
    m_cnt  = 4'(distinct);
    m_err  = (distinct != q.size()) || (q.size() > MAX1);
    m_pend = 1'b1;
    q.delete();
  endtask

  // One cycle on the main DUT: drive at negedge, sample 1ns later, score, then advance the model.
  task automatic step(input logic v, input logic [2:0] p, input logic z, input logic l,
                      input logic r, output bit acc);
    bit ret;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_pos    = p;
    bus.in_zero   = z;
    bus.in_last   = l;
    bus.out_ready = r;
    #1;
    s_ready = bus.in_ready;
    s_valid = bus.out_valid;
    s_mask  = bus.out_mask;
    s_count = bus.out_count;
    s_err   = bus.out_err;
    chk("in_ready", 32'(s_ready), 32'(!m_pend || r));
    chk("out_valid", 32'(s_valid), 32'(m_pend));
    if (m_pend) begin
      chk("sb_mask", 32'(s_mask), 32'(m_mask));
      chk("sb_count", 32'(s_count), 32'(m_cnt));
      chk("sb_err", 32'(s_err), 32'(m_err));
    end
    acc = v && s_ready;
    ret = s_valid && r;
    if (ret) m_pend = 1'b0;
    if (acc) begin
      if (!z) q.push_back(int'(p));
      if (l) model_close();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus2.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_pend = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic b2_beat(input logic [2:0] p, input logic l);
    @(negedge clk);
    bus2.in_valid = 1'b1;
    bus2.in_pos   = p;
    bus2.in_zero  = 1'b0;
    bus2.in_last  = l;
    #1;
    chk("max2_in_ready", 32'(bus2.in_ready), 32'd1);
  endtask

  task automatic b2_check(input logic [7:0] m, input logic [3:0] c, input logic e);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    #1;
    chk("max2_valid", 32'(bus2.out_valid), 32'd1);
    chk("max2_mask", 32'(bus2.out_mask), 32'(m));
    chk("max2_count", 32'(bus2.out_count), 32'(c));
    chk("max2_err", 32'(bus2.out_err), 32'(e));
  endtask

  initial begin
    bit acc;
    checks = 0;
    failures = 0;
    m_pend = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b0;  bus.in_pos = '0;  bus.in_zero = 1'b0;  bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_pos = '0; bus2.in_zero = 1'b0; bus2.in_last = 1'b0;
    bus2.out_ready = 1'b1;

    vecs[0] = '{1, {3'd0, 21'd0},                      8'h00, 8'h80, 4'd1, 1'b0};
    vecs[1] = '{3, {3'd1, 3'd3, 3'd7, 15'd0},          8'h00, 8'h51, 4'd3, 1'b0};
    vecs[2] = '{1, {3'd5, 21'd0},                      8'h80, 8'h00, 4'd0, 1'b0};
    vecs[3] = '{2, {3'd2, 3'd2, 18'd0},                8'h00, 8'h20, 4'd1, 1'b1};
    vecs[4] = '{2, {3'd6, 3'd4, 18'd0},                8'h80, 8'h08, 4'd1, 1'b0};
    vecs[5] = '{8, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8'h00, 8'hFF, 4'd8, 1'b0};
    vecs[6] = '{3, {3'd7, 3'd7, 3'd7, 15'd0},          8'h00, 8'h01, 4'd1, 1'b1};

    do_reset();

    // Directed word table; each word is held one cycle with out_ready low, then compared.
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < vecs[k].n; i++) begin
        step(1'b1, vecs[k].pos[23 - 3*i -: 3], vecs[k].zero[7 - i], 1'(i == vecs[k].n - 1), 1'b1, acc);
        chk($sformatf("vec%0d_accept", k), 32'(acc), 32'd1);
      end
      step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, acc);
      chk($sformatf("vec%0d_valid", k), 32'(s_valid), 32'd1);
      chk($sformatf("vec%0d_mask", k), 32'(s_mask), 32'(vecs[k].exp_mask));
      chk($sformatf("vec%0d_count", k), 32'(s_count), 32'(vecs[k].exp_count));
      chk($sformatf("vec%0d_err", k), 32'(s_err), 32'(vecs[k].exp_err));
    end

    // Backpressure: word frozen, beat refused, then retire and start a fresh word in one cycle.
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 3'd1, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, acc);
      chk("hold_no_accept", 32'(acc), 32'd0);
      chk("hold_in_ready", 32'(s_ready), 32'd0);
      chk("hold_mask", 32'(s_mask), 32'hC0);
    end
    step(1'b1, 3'd7, 1'b0, 1'b1, 1'b1, acc);
    chk("swap_accept", 32'(acc), 32'd1);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, acc);
    chk("swap_valid", 32'(s_valid), 32'd1);
    chk("swap_mask", 32'(s_mask), 32'h01);
    chk("swap_count", 32'(s_count), 32'd1);

    // Mid-word reset discards the partial word.
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b1, acc);
    do_reset();
    step(1'b1, 3'd5, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, acc);
    chk("rstmid_mask", 32'(s_mask), 32'h04);
    chk("rstmid_count", 32'(s_count), 32'd1);
    chk("rstmid_err", 32'(s_err), 32'd0);
    do_reset();

    // Term limit on the MAX_TERMS=2 instance.
    b2_beat(3'd0, 1'b0);
    b2_beat(3'd1, 1'b0);
    b2_beat(3'd2, 1'b1);
    b2_check(8'hE0, 4'd3, 1'b1);
    b2_beat(3'd0, 1'b0);
    b2_beat(3'd1, 1'b1);
    b2_check(8'hC0, 4'd2, 1'b0);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 800; c++) begin
      step(1'(($urandom % 4) != 0), 3'($urandom_range(0, 7)), 1'(($urandom % 6) == 0),
           1'(($urandom % 4) == 0), 1'(($urandom % 3) != 0), acc);
    end
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
